sprite_mover: RTL
=================

SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter SCREEN_W, default 800: visible width in pixels.
REQ-002 Parameter SCREEN_H, default 600: visible height in pixels.
REQ-003 Parameter SPR_W, default 16: sprite width in pixels.
REQ-004 Parameter SPR_H, default 16: sprite height in pixels.
REQ-005 Port i_pix_clk, input, 1: the single pixel clock (40 MHz); all logic is clocked on its rising edge.
REQ-006 Port i_reset, input, 1: asynchronous, active-high reset.
REQ-007 Port i_vert_sync, input, 1: vertical sync from the VGA controller, synchronous to i_pix_clk, active-high pulse.
REQ-008 Port i_enable, input, 1: motion enable; while low, frame updates are suppressed.
REQ-009 Port i_speed, input, 4: pixels moved per frame on each axis.
REQ-010 Port o_x_coord, output, 16: sprite left edge, feeds the sprite renderer's i_x_coord.
REQ-011 Port o_y_coord, output, 16: sprite top edge, feeds the sprite renderer's i_y_coord.
REQ-012 Port o_frame_tick, output, 1: one-cycle pulse when a new position is committed.
REQ-013 Port o_bounce_x, output, 1: one-cycle pulse, coincident with o_frame_tick, when X direction flipped.
REQ-014 Port o_bounce_y, output, 1: one-cycle pulse, coincident with o_frame_tick, when Y direction flipped.

Function
REQ-015 The block SHALL register i_vert_sync and detect its rising edge synchronously; it SHALL NOT clock any logic on i_vert_sync.
REQ-016 The FSM SHALL have states IDLE, CALC_X, CALC_Y and COMMIT, with transitions IDLE->CALC_X on rising edge & i_enable, then CALC_X->CALC_Y->COMMIT->IDLE unconditionally.
REQ-017 i_speed SHALL be latched on IDLE->CALC_X; changes mid-update have no effect until the next frame.
REQ-018 Edge detected in cycle k: o_x_coord, o_y_coord, o_frame_tick and o_bounce_* SHALL update at the clock edge ending cycle k+3 (visible in cycle k+4); o_frame_tick is high for exactly that one cycle.
REQ-019 Working X/Y SHALL be computed into shadow registers; outputs change only in COMMIT, so both coordinates update on the same clock edge.
REQ-020 Positive direction: next = pos + speed in 17 bits; if next >= SCREEN_W-SPR_W (SCREEN_H-SPR_H for Y), clamp pos to that limit, flip direction, and pulse the axis bounce flag.
REQ-021 Negative direction: if pos <= speed, set pos to 0, flip direction, and pulse the axis bounce flag; else pos = pos - speed.
REQ-022 speed == 0 SHALL leave position and direction unchanged with no bounce, but o_frame_tick SHALL still pulse.
REQ-023 Rising edges of i_vert_sync outside IDLE, or with i_enable low, SHALL be ignored without queuing.
REQ-024 o_x_coord SHALL always lie in [0, SCREEN_W-SPR_W] and o_y_coord in [0, SCREEN_H-SPR_H].

Reset
REQ-025 i_reset high SHALL asynchronously force: FSM=IDLE, o_x_coord=0, o_y_coord=0, shadow X/Y=0, X and Y directions positive, o_frame_tick=0, o_bounce_x=0, o_bounce_y=0, and the registered vsync=0.
REQ-026 Reset asserted mid-update SHALL abandon the update; no commit or tick follows reset release.

Structure
REQ-027 SCREEN_W/SCREEN_H defaults and FSM state encodings SHALL live in the shared vga_params package, shared with the VGA controller and sprite renderer.
REQ-028 Per-axis clamp/flip arithmetic SHALL be one sub-module, axis_stepper, instantiated twice (X, Y) with the limit as a parameter.

Verification
REQ-029 Reset, i_enable=1, i_speed=4, one vsync pulse -> x=4, y=4, o_frame_tick high exactly 4 cycles after the edge cycle, for 1 cycle.
REQ-030 i_speed=8, 73 frames -> y=584, o_bounce_y pulses on frame 73; frame 74 -> y=576.
REQ-031 i_speed=8, 98 frames -> x=784, o_bounce_x pulses on frame 98; frame 99 -> x=776.
REQ-032 After frame 99, i_speed=15 for 52 frames -> x reaches 0 via clamp (776-51*15=11, 11<=15), o_bounce_x pulses on frame 151; frame 152 -> x=15.
REQ-033 i_enable=0 for 10 vsync pulses -> coordinates unchanged, no tick or bounce pulses.
REQ-034 i_reset pulsed during CALC_Y with x=40 -> x=y=0 immediately, no tick after release; i_speed=0 frame -> tick only, coordinates unchanged.

Source files
------------

// File: rtl/vga_params.sv
// Shared VGA timing and FSM parameters used by the controller, renderer and sprite mover.
package vga_params;
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;
  localparam int COORD_W      = 16;

  // Sprite mover FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC_X = 2'd1;
  localparam logic [1:0] ST_CALC_Y = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Result of one per-axis step
  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir_neg;
    logic               bounce;
  } step_t;
endpackage

// File: rtl/axis_stepper.sv
// One axis of sprite motion: advance by speed, clamp at 0 / LIMIT and flip direction.
module axis_stepper
  import vga_params::*;
#(
  parameter int LIMIT = 784
) (
  input  logic [COORD_W-1:0] pos,
  input  logic               dir_neg,
  input  logic [3:0]         speed,
  output step_t              res
);
  logic [COORD_W:0] sum;

  assign sum = {1'b0, pos} + {13'd0, speed};

  // Clamp-and-flip step; speed 0 is a pure hold so it can never bounce.
  always_comb begin
    res.pos     = pos;
    res.dir_neg = dir_neg;
    res.bounce  = 1'b0;
    if (speed != 4'd0) begin
      if (!dir_neg) begin
        if (sum >= (COORD_W+1)'(LIMIT)) begin
          res.pos     = COORD_W'(LIMIT);
          res.dir_neg = 1'b1;
          res.bounce  = 1'b1;
        end else begin
          res.pos = sum[COORD_W-1:0];
        end
      end else begin
        if (pos <= {12'd0, speed}) begin
          res.pos     = '0;
          res.dir_neg = 1'b0;
          res.bounce  = 1'b1;
        end else begin
          res.pos = pos - {12'd0, speed};
        end
      end
    end
  end
endmodule

// File: rtl/sprite_mover.sv
// Bouncing sprite position generator, stepped once per vertical sync.
module sprite_mover
  import vga_params::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16
) (
  input  logic                i_pix_clk,
  input  logic                i_reset,
  input  logic                i_vert_sync,
  input  logic                i_enable,
  input  logic [3:0]          i_speed,
  output logic [COORD_W-1:0]  o_x_coord,
  output logic [COORD_W-1:0]  o_y_coord,
  output logic                o_frame_tick,
  output logic                o_bounce_x,
  output logic                o_bounce_y
);
  localparam int NUM_AXES = 2;

  logic                              vs_q;
  logic                              vs_rise;
  logic [1:0]                        state;
  logic [3:0]                        spd_q;
  logic [NUM_AXES-1:0][COORD_W-1:0]  shd_pos;
  logic [NUM_AXES-1:0]               dir_neg;
  logic [NUM_AXES-1:0]               bnc_pend;
  step_t [NUM_AXES-1:0]              step_res;

  assign vs_rise = i_vert_sync & ~vs_q;

  // Axis 0 is X, axis 1 is Y; only the travel limit differs.
  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    axis_stepper #(
      .LIMIT((a == 0) ? (SCREEN_W - SPR_W) : (SCREEN_H - SPR_H))
    ) u_step (
      .pos     (shd_pos[a]),
      .dir_neg (dir_neg[a]),
      .speed   (spd_q),
      .res     (step_res[a])
    );
  end

  // Register vsync so its rising edge is seen as a data event, never a clock.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) vs_q <= 1'b0;
    else         vs_q <= i_vert_sync;
  end

  // Update sequencer; edges arriving outside IDLE are dropped, not queued.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      spd_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (vs_rise && i_enable) begin
          state <= ST_CALC_X;
          spd_q <= i_speed;
        end
        ST_CALC_X: state <= ST_CALC_Y;
        ST_CALC_Y: state <= ST_COMMIT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Shadow position/direction work: X in CALC_X, Y in CALC_Y.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      shd_pos  <= '0;
      dir_neg  <= '0;
      bnc_pend <= '0;
    end else if (state == ST_CALC_X) begin
      shd_pos[0]  <= step_res[0].pos;
      dir_neg[0]  <= step_res[0].dir_neg;
      bnc_pend[0] <= step_res[0].bounce;
    end else if (state == ST_CALC_Y) begin
      shd_pos[1]  <= step_res[1].pos;
      dir_neg[1]  <= step_res[1].dir_neg;
      bnc_pend[1] <= step_res[1].bounce;
    end
  end

  // Commit both coordinates on one edge, with single-cycle tick and bounce pulses.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      o_x_coord    <= '0;
      o_y_coord    <= '0;
      o_frame_tick <= 1'b0;
      o_bounce_x   <= 1'b0;
      o_bounce_y   <= 1'b0;
    end else if (state == ST_COMMIT) begin
      o_x_coord    <= shd_pos[0];
      o_y_coord    <= shd_pos[1];
      o_frame_tick <= 1'b1;
      o_bounce_x   <= bnc_pend[0];
      o_bounce_y   <= bnc_pend[1];
    end else begin
      o_frame_tick <= 1'b0;
      o_bounce_x   <= 1'b0;
      o_bounce_y   <= 1'b0;
    end
  end
endmodule
